// File: rtl/piso_pkg.sv
// Shared types for the parallel-in serial-out serializer.
// Holds the FSM state encoding used by the top level.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/piso_bit_counter.sv
// Bit position counter for one serial frame.
// Saturates at WIDTH-1; the owner clears it to start a frame.
module piso_bit_counter #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic clear,
    input  logic increment,
    output logic last
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, then increment, else hold.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (increment && !last) begin
            count_d = count_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign last = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with valid/ready load side.
// Supports seamless back-to-back words and downstream stalls.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] parallel_data_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             serial_data_out,
    output logic             serial_valid,
    output logic             busy,
    output logic             done
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;
    logic             done_q;
    logic             done_d;

    logic             last;
    logic             consume;
    logic             accept;
    logic             cnt_clear;
    logic             cnt_inc;
    logic [WIDTH-1:0] shifted;
    logic             head;

    piso_bit_counter #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .clk      (clk),
        .clear    (cnt_clear),
        .increment(cnt_inc),
        .last     (last)
    );

    // Handshake, shift direction and next-state decode.
    always_comb begin
        consume    = (state_q == SHIFT) && shift_en;
        load_ready = (state_q == IDLE) || (consume && last);
        accept     = load_valid && load_ready;
        if (MSB_FIRST != 0) begin
            shifted = {sreg_q[WIDTH-2:0], 1'b0};
            head    = sreg_q[WIDTH-1];
        end else begin
            shifted = {1'b0, sreg_q[WIDTH-1:1]};
            head    = sreg_q[0];
        end
        cnt_clear = reset || accept || (consume && last);
        cnt_inc   = consume && !last;
        state_d   = state_q;
        sreg_d    = sreg_q;
        done_d    = consume && last;
        if (accept) begin
            state_d = SHIFT;
            sreg_d  = parallel_data_in;
        end else if (consume) begin
            sreg_d = shifted;
            if (last) begin
                state_d = IDLE;
            end
        end
    end

    // FSM state, shift register and done pulse; reset aborts any frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            done_q  <= done_d;
        end
    end

    assign serial_valid    = (state_q == SHIFT);
    assign busy            = serial_valid;
    assign serial_data_out = serial_valid && head;
    assign done            = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer, LSB- and MSB-first.
// Directed vector table, hand sequences, then random vs queue model.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       lv;
    logic       se;
    logic       rdy0, sdo0, vld0, bsy0, dn0;
    logic       rdy1, sdo1, vld1, bsy1, dn1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
        .clk             (clk),
        .reset           (reset),
        .parallel_data_in(din),
        .load_valid      (lv),
        .load_ready      (rdy0),
        .shift_en        (se),
        .serial_data_out (sdo0),
        .serial_valid    (vld0),
        .busy            (bsy0),
        .done            (dn0)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (
        .clk             (clk),
        .reset           (reset),
        .parallel_data_in(din),
        .load_valid      (lv),
        .load_ready      (rdy1),
        .shift_en        (se),
        .serial_data_out (sdo1),
        .serial_valid    (vld1),
        .busy            (bsy1),
        .done            (dn1)
    );

    typedef struct {
        logic       rst;
        logic       lv;
        logic [7:0] d;
        logic       se;
        logic       sdo0;
        logic       sdo1;
        logic       vld;
        logic       dn;
        logic       rdy;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t act=%b exp=%b", nm, $time, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic l,
                         input logic [7:0] d, input logic s);
        @(negedge clk);
        reset = r;
        lv    = l;
        din   = d;
        se    = s;
        #1;
    endtask

    task automatic chk_all(input string tag, input logic e0,
                           input logic e1, input logic v,
                           input logic dn, input logic r);
        chk({tag, ".sdo_lsb"}, sdo0, e0);
        chk({tag, ".sdo_msb"}, sdo1, e1);
        chk({tag, ".valid"}, vld0, v);
        chk({tag, ".valid_m"}, vld1, v);
        chk({tag, ".busy"}, bsy0, v);
        chk({tag, ".busy_m"}, bsy1, v);
        chk({tag, ".done"}, dn0, dn);
        chk({tag, ".done_m"}, dn1, dn);
        chk({tag, ".ready"}, rdy0, r);
        chk({tag, ".ready_m"}, rdy1, r);
    endtask

    task automatic push(input logic r, input logic l, input logic [7:0] d,
                        input logic s, input logic e0, input logic e1,
                        input logic v, input logic dn, input logic rd);
        vec_t t;
        t.rst = r; t.lv = l; t.d = d; t.se = s;
        t.sdo0 = e0; t.sdo1 = e1; t.vld = v; t.dn = dn; t.rdy = rd;
        vq.push_back(t);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    bit mq0[$];
    bit mq1[$];
    bit mdone;

    initial begin
        logic [7:0] w;
        logic [7:0] f;
        reset = 1'b1; lv = 1'b0; din = 8'h00; se = 1'b0;

        do_reset();
        chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        w = 8'hC1;
        f = 8'hFF;
        push(0, 1, w, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++)
            push(0, 0, 8'h00, 1, w[i], w[7-i], 1, 0, i == 7);
        push(0, 0, 8'h00, 1, 0, 0, 0, 1, 1);
        push(0, 0, 8'h00, 0, 0, 0, 0, 0, 1);
        push(0, 1, w, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++)
            push(0, 1, f, 1, w[i], w[7-i], 1, 0, i == 7);
        for (int i = 0; i < 8; i++)
            push(0, 0, 8'h00, 1, f[i], f[7-i], 1, i == 0, i == 7);
        push(0, 0, 8'h00, 0, 0, 0, 0, 1, 1);
        push(0, 0, 8'h00, 0, 0, 0, 0, 0, 1);

        for (int k = 0; k < vq.size(); k++) begin
            drive(vq[k].rst, vq[k].lv, vq[k].d, vq[k].se);
            chk_all($sformatf("vec%0d", k), vq[k].sdo0, vq[k].sdo1,
                    vq[k].vld, vq[k].dn, vq[k].rdy);
        end

        drive(0, 1, w, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 8'h00, 1);
            chk_all($sformatf("stall_b%0d", i), w[i], w[7-i], 1, 0, 0);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 8'h00, 0);
            chk_all($sformatf("stall_hold%0d", i), w[3], w[4], 1, 0, 0);
        end
        for (int i = 3; i < 8; i++) begin
            drive(0, 0, 8'h00, 1);
            chk_all($sformatf("stall_b%0d", i), w[i], w[7-i], 1, 0, i == 7);
        end
        drive(0, 0, 8'h00, 0);
        chk_all("stall_done", 0, 0, 0, 1, 1);

        drive(0, 1, w, 0);
        drive(0, 0, 8'h00, 1);
        chk_all("ign_b0", w[0], w[7], 1, 0, 0);
        for (int i = 1; i < 7; i++) begin
            drive(0, 1, 8'h00, 1);
            chk_all($sformatf("ign_b%0d", i), w[i], w[7-i], 1, 0, 0);
        end
        drive(0, 0, 8'h00, 1);
        chk_all("ign_b7", w[7], w[0], 1, 0, 1);
        drive(0, 0, 8'h00, 0);
        chk_all("ign_done", 0, 0, 0, 1, 1);

        drive(0, 1, w, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 8'h00, 1);
            chk_all($sformatf("rst_b%0d", i), w[i], w[7-i], 1, 0, 0);
        end
        drive(1, 0, 8'h00, 1);
        drive(0, 0, 8'h00, 1);
        chk_all("rst_after", 0, 0, 0, 0, 1);
        drive(0, 0, 8'h00, 0);
        chk_all("rst_nodone", 0, 0, 0, 0, 1);

        do_reset();
        mq0.delete();
        mq1.delete();
        mdone = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic r, l, s, ev, er, e0, e1;
            logic [7:0] d;
            r = ($urandom_range(0, 49) == 0);
            l = $urandom_range(0, 1);
            s = ($urandom_range(0, 3) != 0);
            d = 8'($urandom);
            drive(r, l, d, s);
            ev = (mq0.size() > 0);
            e0 = ev ? mq0[0] : 1'b0;
            e1 = ev ? mq1[0] : 1'b0;
            er = (mq0.size() == 0) || (s && mq0.size() == 1);
            chk_all("rand", e0, e1, ev, mdone, er);
            @(posedge clk);
            if (r) begin
                mq0.delete();
                mq1.delete();
                mdone = 1'b0;
            end else begin
                mdone = s && (mq0.size() == 1);
                if (s && mq0.size() > 0) begin
                    void'(mq0.pop_front());
                    void'(mq1.pop_front());
                end
                if (l && er) begin
                    for (int i = 0; i < 8; i++) begin
                        mq0.push_back(d[i]);
                        mq1.push_back(d[7-i]);
                    end
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, parallel word width in bits; legal range 2..32.
REQ-002 SHALL have parameter MSB_FIRST, default 0, where 0 means LSB shifted out first and 1 means MSB shifted out first.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port parallel_data_in, input, WIDTH bits: word to serialise.
REQ-006 SHALL have port load_valid, input, 1 bit: upstream offers parallel_data_in.
REQ-007 SHALL have port load_ready, output, 1 bit: block can accept a word this cycle.
REQ-008 SHALL have port shift_en, input, 1 bit: downstream consumes the current serial bit this cycle.
REQ-009 SHALL have port serial_data_out, output, 1 bit: current head bit.
REQ-010 SHALL have port serial_valid, output, 1 bit: serial_data_out holds a live bit.
REQ-011 SHALL have port busy, output, 1 bit: frame in progress; equals serial_valid.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse after the last bit of a word is consumed.

Function
REQ-013 SHALL implement two states: IDLE and SHIFT.
REQ-014 SHALL accept a word on a rising edge where load_valid and load_ready are both 1; that edge captures parallel_data_in into the shift register, clears the bit counter and enters SHIFT.
REQ-015 SHALL drive load_ready combinationally as: 1 in IDLE; 1 in SHIFT only when shift_en=1 and bit counter = WIDTH-1; 0 otherwise.
REQ-016 SHALL drive serial_data_out from the shift register head: bit 0 when MSB_FIRST=0, bit WIDTH-1 when MSB_FIRST=1; serial_valid=1 exactly in SHIFT.
REQ-017 SHALL present the first bit of an accepted word in the cycle immediately after the accepting edge, with zero idle cycles of latency.
REQ-018 SHALL, on each edge in SHIFT with shift_en=1, shift the register one position toward the head, fill the vacated end with 0, and increment the counter.
REQ-019 SHALL hold the register, counter and serial_data_out unchanged in SHIFT when shift_en=0, with no timeout.
REQ-020 SHALL, on the consuming edge of bit WIDTH-1, return to IDLE, unless a new word is accepted on that same edge, in which case it stays in SHIFT with the new word loaded (seamless back-to-back).
REQ-021 SHALL assert done for exactly the one cycle following the consuming edge of bit WIDTH-1, including in the back-to-back case.
REQ-022 SHALL ignore shift_en in IDLE; serial_data_out SHALL be 0 in IDLE.
REQ-023 SHALL ignore load_valid while load_ready=0 and SHALL NOT corrupt the frame in progress.
REQ-024 SHALL size the counter at $clog2(WIDTH) bits and SHALL NOT let it wrap inside a frame.

Reset
REQ-025 SHALL, while reset=1 at a rising edge, set state=IDLE, shift register=0, counter=0 and done=0; this gives serial_data_out=0, serial_valid=0, busy=0, load_ready=1 after the edge.
REQ-026 SHALL give reset priority over load and shift; a reset mid-frame SHALL abort the frame with no done pulse.

Structure
REQ-027 SHALL take the state enum (IDLE, SHIFT) from shared package piso_pkg.
REQ-028 SHALL keep the bit counter in sub-module piso_bit_counter, with inputs clear and increment and an output flag for last bit (count = WIDTH-1).

Verification
REQ-029 SHALL verify WIDTH=8, MSB_FIRST=0: load 0xC1, shift_en held 1 -> serial_data_out 1,0,0,0,0,0,1,1 on 8 consecutive cycles, then done=1 for one cycle, then IDLE.
REQ-030 SHALL verify WIDTH=8, MSB_FIRST=1: load 0xC1 -> serial_data_out 1,1,0,0,0,0,0,1, then done pulse.
REQ-031 SHALL verify a back-to-back load: 0xC1 then 0xFF offered with load_valid held 1 -> 16 contiguous valid bits with no gap and two done pulses 8 cycles apart.
REQ-032 SHALL verify stall: shift_en=0 for 3 cycles after bit 2 -> serial_data_out frozen and bit 3 appears only after shift_en returns; total frame still 8 consumed bits.
REQ-033 SHALL verify that load_valid=1 with 0x00 mid-frame is ignored -> remaining bits of 0xC1 are unchanged.
REQ-034 SHALL verify reset asserted at bit 4 -> next cycle serial_valid=0, serial_data_out=0, load_ready=1, and no done pulse.
